fixed_point_division_ctrl: RTL

Control FSM that sequences the 10-bit fixed-point division datapath (A/B/ACC/Q registers, subtractor, comparator, overflow detector) through one complete restoring division per `start`. It owns the 14-iteration schedule, the load/clear/shift/subtract strobes and the divide-by-zero and overflow abort paths. It reports `busy`, a one-cycle `done` and sticky `ov`/`dz` status to the surrounding system. The datapath stays purely a slave to this block.

---
 rtl/fixed_point_division_ctrl.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fixed_point_division_ctrl.sv
// ----------------------------------------------------------------------------
// fixed_point_division_ctrl
//
// Control FSM for a 10-bit fixed-point restoring divider. It sequences the
// datapath (A/B/ACC/Q registers, subtractor, comparator, overflow detector)
// through one division per accepted start. It owns the iteration schedule,
// the load/clear/shift/subtract strobes, and the divide-by-zero and overflow
// abort paths.
//
// Ports:
//   i_clk, i_rst     clock; synchronous active-high reset
//   i_start          begin a division (sampled only in IDLE)
//   i_b_zero         divisor is zero (sampled in INIT)
//   i_gt             comparator ACC >= B after shift (combinational)
//   i_ov_in          overflow detector flag (sampled in ITER)
//   o_ld_a, o_ld_b   load operand registers
//   o_acc_clr        clear ACC
//   o_q_init         load Q from A
//   o_shift_en       shift ACC:Q left one bit
//   o_sub_sel        ACC takes the subtractor result this step
//   o_q_bit          quotient bit shifted into Q LSB
//   o_iter_cnt       current iteration index
//   o_busy           division in progress (LOAD/INIT/ITER)
//   o_done           one-cycle completion pulse
//   o_ov, o_dz       sticky overflow / divide-by-zero status
// ----------------------------------------------------------------------------
module fixed_point_division_ctrl #(
    parameter int ITERATIONS = 14,
    parameter int CNT_W      = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_b_zero,
    input  logic             i_gt,
    input  logic             i_ov_in,
    output logic             o_ld_a,
    output logic             o_ld_b,
    output logic             o_acc_clr,
    output logic             o_q_init,
    output logic             o_shift_en,
    output logic             o_sub_sel,
    output logic             o_q_bit,
    output logic [CNT_W-1:0] o_iter_cnt,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_ov,
    output logic             o_dz
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INIT,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ITERATIONS - 1);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_iter_cnt;
    logic             r_ov;
    logic             r_dz;
    logic             w_last;

    assign w_last = (r_iter_cnt == LAST_IDX);

    // State register plus counter and sticky status
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_iter_cnt <= '0;
            r_ov       <= 1'b0;
            r_dz       <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_ov <= 1'b0;
                        r_dz <= 1'b0;
                    end
                end
                S_INIT: begin
                    r_iter_cnt <= '0;
                    if (i_b_zero) r_dz <= 1'b1;
                end
                S_ITER: begin
                    // Saturate at the last index so the count never wraps
                    if (!w_last) r_iter_cnt <= r_iter_cnt + 1'b1;
                    if (i_ov_in) r_ov <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and strobe decode
    always_comb begin
        w_next     = r_state;
        o_ld_a     = 1'b0;
        o_ld_b     = 1'b0;
        o_acc_clr  = 1'b0;
        o_q_init   = 1'b0;
        o_shift_en = 1'b0;
        o_sub_sel  = 1'b0;
        o_q_bit    = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) w_next = S_LOAD;
            end
            S_LOAD: begin
                o_ld_a = 1'b1;
                o_ld_b = 1'b1;
                o_busy = 1'b1;
                w_next = S_INIT;
            end
            S_INIT: begin
                o_acc_clr = 1'b1;
                o_q_init  = 1'b1;
                o_busy    = 1'b1;
                w_next    = i_b_zero ? S_DONE : S_ITER;
            end
            S_ITER: begin
                o_shift_en = 1'b1;
                o_sub_sel  = i_gt;
                o_q_bit    = i_gt;
                o_busy     = 1'b1;
                // Overflow on the final step lands in the same DONE transition
                if (i_ov_in || w_last) w_next = S_DONE;
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign o_iter_cnt = r_iter_cnt;
    assign o_ov       = r_ov;
    assign o_dz       = r_dz;

endmodule
